// File: rtl/sdr_cmd_receive_gen_if.sv
// rtl/sdr_cmd_receive_gen_if.sv - UDP RX stream, reply/erase handshakes and EPCS FIFO write port
interface sdr_cmd_receive_gen_if #(
  parameter int FIFO_AW = 10
);
  logic [7:0]         udp_rx_data;
  logic               udp_rx_active;
  logic [15:0]        to_port;
  logic               broadcast;
  logic [47:0]        local_mac;
  logic               sending_sync;
  logic               discovery_ack;
  logic               erase_ack;
  logic [FIFO_AW-1:0] fifo_wrused;
  logic               discovery_reply;
  logic               erase;
  logic               seq_error;
  logic               set_ip;
  logic [31:0]        assign_ip;
  logic [31:0]        num_blocks;
  logic [31:0]        sequence_number;
  logic               fifo_wr;
  logic [7:0]         fifo_data;
  logic               pkt_drop;

  modport master (
    output udp_rx_data, udp_rx_active, to_port, broadcast, local_mac,
           sending_sync, discovery_ack, erase_ack, fifo_wrused,
    input  discovery_reply, erase, seq_error, set_ip, assign_ip, num_blocks,
           sequence_number, fifo_wr, fifo_data, pkt_drop
  );

  modport slave (
    input  udp_rx_data, udp_rx_active, to_port, broadcast, local_mac,
           sending_sync, discovery_ack, erase_ack, fifo_wrused,
    output discovery_reply, erase, seq_error, set_ip, assign_ip, num_blocks,
           sequence_number, fifo_wr, fifo_data, pkt_drop
  );
endinterface

// File: rtl/sdr_cmd_receive_gen.sv
// rtl/sdr_cmd_receive_gen.sv - Protocol-2 command receiver: discovery, set-IP, erase, program
module sdr_cmd_receive_gen #(
  parameter logic [15:0] LISTEN_PORT = 16'd1024,
  parameter int          BLOCK_BYTES = 256,
  parameter int          FIFO_AW     = 10,
  parameter int          FIFO_DEPTH  = 1024,
  parameter int          ACK_TO_W    = 27
) (
  input logic                  rx_clock,
  input logic                  reset_n,
  sdr_cmd_receive_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, DISC, SETIP, ERASE, PROG, TX, WAIT} state_e;

  localparam logic [15:0]        LAST_BYTE  = 16'(8 + BLOCK_BYTES);
  localparam logic [FIFO_AW:0]   DROP_LEVEL = (FIFO_AW+1)'(FIFO_DEPTH - BLOCK_BYTES);
  // Request drops on the edge where its timer would reach all-ones.
  localparam logic [ACK_TO_W-1:0] TO_LAST   = {{(ACK_TO_W-1){1'b1}}, 1'b0};

  state_e              state_q;
  logic [15:0]         cnt_q;
  logic [31:0]         seq_shift_q, last_prog_q, sequence_number_q, assign_ip_q, num_blocks_q;
  logic                first_prog_q, seq_error_q, set_ip_q, disc_q, erase_q;
  logic                fifo_wr_q, pkt_drop_q;
  logic [7:0]          fifo_data_q;
  logic [ACK_TO_W-1:0] disc_tmr_q, erase_tmr_q;

  logic       active, at_cmd, disc_req, erase_req, over_full;
  logic [7:0] rx_byte, mac_byte;

  assign active    = bus.udp_rx_active;
  assign rx_byte   = bus.udp_rx_data;
  assign at_cmd    = (state_q == HDR) && active && (cnt_q == 16'd4);
  assign disc_req  = at_cmd && (rx_byte == 8'd2);
  assign erase_req = at_cmd && (rx_byte == 8'd4) && !bus.broadcast;
  assign over_full = {1'b0, bus.fifo_wrused} > DROP_LEVEL;

  always_comb begin
    mac_byte = 8'h00;
    case (cnt_q[3:0])
      4'd5:    mac_byte = bus.local_mac[47:40];
      4'd6:    mac_byte = bus.local_mac[39:32];
      4'd7:    mac_byte = bus.local_mac[31:24];
      4'd8:    mac_byte = bus.local_mac[23:16];
      4'd9:    mac_byte = bus.local_mac[15:8];
      4'd10:   mac_byte = bus.local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= 16'd0;
      seq_shift_q       <= 32'd0;
      last_prog_q       <= 32'd0;
      sequence_number_q <= 32'd0;
      assign_ip_q       <= 32'd0;
      num_blocks_q      <= 32'd0;
      first_prog_q      <= 1'b1;
      seq_error_q       <= 1'b0;
      set_ip_q          <= 1'b0;
      disc_q            <= 1'b0;
      erase_q           <= 1'b0;
      fifo_wr_q         <= 1'b0;
      pkt_drop_q        <= 1'b0;
      fifo_data_q       <= 8'd0;
      disc_tmr_q        <= '0;
      erase_tmr_q       <= '0;
    end else begin
      fifo_wr_q  <= 1'b0;
      pkt_drop_q <= 1'b0;
      if (active && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;

      case (state_q)
        IDLE: if (active && bus.to_port == LISTEN_PORT) begin
          seq_shift_q <= {seq_shift_q[23:0], rx_byte};
          cnt_q       <= 16'd1;
          state_q     <= HDR;
        end
        HDR: begin
          if (!active) state_q <= IDLE;
          else if (cnt_q < 16'd4) seq_shift_q <= {seq_shift_q[23:0], rx_byte};
          else begin
            state_q <= WAIT;
            case (rx_byte)
              8'd2: begin
                state_q           <= DISC;
                sequence_number_q <= seq_shift_q;
              end
              8'd3: if (bus.broadcast) begin
                state_q           <= SETIP;
                sequence_number_q <= seq_shift_q;
              end
              8'd4: if (!bus.broadcast) begin
                state_q           <= ERASE;
                sequence_number_q <= seq_shift_q;
              end
              8'd5: if (!bus.broadcast) begin
                if (over_full) pkt_drop_q <= 1'b1;
                else begin
                  state_q           <= PROG;
                  sequence_number_q <= seq_shift_q;
                  last_prog_q       <= seq_shift_q;
                  first_prog_q      <= 1'b0;
                  if (!first_prog_q && seq_shift_q != last_prog_q + 32'd1) seq_error_q <= 1'b1;
                end
              end
              default: state_q <= WAIT;
            endcase
          end
        end
        DISC, ERASE: state_q <= active ? TX : IDLE;
        SETIP: begin
          if (!active) state_q <= IDLE;
          else if (cnt_q <= 16'd10) begin
            if (rx_byte != mac_byte) state_q <= WAIT;
          end else begin
            assign_ip_q <= {assign_ip_q[23:0], rx_byte};
            if (cnt_q == 16'd14) begin
              set_ip_q <= 1'b1;
              state_q  <= WAIT;
            end
          end
        end
        PROG: begin
          if (!active) state_q <= IDLE;
          else if (cnt_q <= 16'd8) num_blocks_q <= {num_blocks_q[23:0], rx_byte};
          else begin
            fifo_wr_q   <= 1'b1;
            fifo_data_q <= rx_byte;
            if (cnt_q == LAST_BYTE) state_q <= WAIT;
          end
        end
        TX:      if (!bus.sending_sync && !active) state_q <= IDLE;
        WAIT:    if (!active) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // Handshakes run independently of the packet parser once raised.
      if (disc_q) begin
        disc_tmr_q <= disc_tmr_q + 1'b1;
        if (bus.discovery_ack || disc_tmr_q == TO_LAST) disc_q <= 1'b0;
      end else if (disc_req) begin
        disc_q     <= 1'b1;
        disc_tmr_q <= '0;
      end

      if (erase_q) begin
        erase_tmr_q <= erase_tmr_q + 1'b1;
        if (bus.erase_ack || erase_tmr_q == TO_LAST) erase_q <= 1'b0;
      end else if (erase_req) begin
        erase_q      <= 1'b1;
        erase_tmr_q  <= '0;
        first_prog_q <= 1'b1;
        seq_error_q  <= 1'b0;
      end
    end
  end

  assign bus.discovery_reply = disc_q;
  assign bus.erase           = erase_q;
  assign bus.seq_error       = seq_error_q;
  assign bus.set_ip          = set_ip_q;
  assign bus.assign_ip       = assign_ip_q;
  assign bus.num_blocks      = num_blocks_q;
  assign bus.sequence_number = sequence_number_q;
  assign bus.fifo_wr         = fifo_wr_q;
  assign bus.fifo_data       = fifo_data_q;
  assign bus.pkt_drop        = pkt_drop_q;
endmodule

// File: tb/tb_sdr_cmd_receive_gen.sv
// tb/tb_sdr_cmd_receive_gen.sv - table-driven bench for sdr_cmd_receive_gen
module tb_sdr_cmd_receive_gen;
  localparam logic [47:0] MAC = 48'h02005E123456;
  localparam logic [31:0] IP  = 32'hC0A80164;
  localparam logic [31:0] NB  = 32'h00000003;

  typedef struct {
    logic [15:0] port;
    bit          bcast;
    logic [31:0] seq;
    logic [7:0]  cmd;
    int          len;
    bit          mac_good;
    logic [9:0]  wrused;
    int          e_disc;
    int          e_erase;
    int          e_wr;
    int          e_drop;
    bit          e_err;
    logic [31:0] e_seqnum;
    bit          e_setip;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0, drop_cnt = 0, disc_rises = 0, erase_rises = 0, data_bad = 0, pk_wr = 0;
  bit   disc_prev = 0, erase_prev = 0, act_prev = 0;
  int   hi_cnt, s_wr, s_drop, s_disc, s_erase, s_bad;
  logic [2:0] st;
  vec_t vq[$];

  sdr_cmd_receive_gen_if #(.FIFO_AW(10)) bus ();

  sdr_cmd_receive_gen #(
    .LISTEN_PORT(16'd1024), .BLOCK_BYTES(256), .FIFO_AW(10), .FIFO_DEPTH(1024), .ACK_TO_W(4)
  ) dut (
    .rx_clock(clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.udp_rx_active && !act_prev) pk_wr = 0;
    if (bus.fifo_wr) begin
      wr_cnt++;
      if (bus.fifo_data !== 8'((9 + pk_wr) * 7 + 3)) data_bad++;
      pk_wr++;
    end
    if (bus.pkt_drop) drop_cnt++;
    if (bus.discovery_reply && !disc_prev) disc_rises++;
    if (bus.erase && !erase_prev) erase_rises++;
    disc_prev  = bus.discovery_reply;
    erase_prev = bus.erase;
    act_prev   = bus.udp_rx_active;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input logic [31:0] seq,
                                          input logic [7:0] cmd, input bit mac_good);
    if (i < 4) return seq[8*(3-i) +: 8];
    if (i == 4) return cmd;
    if (cmd == 8'd3) begin
      if (i <= 10) return MAC[8*(10-i) +: 8] ^ (mac_good ? 8'h00 : 8'h01);
      if (i <= 14) return IP[8*(14-i) +: 8];
      return 8'h00;
    end
    if (i <= 8) return NB[8*(8-i) +: 8];
    return 8'(i * 7 + 3);
  endfunction

  task automatic send_pkt(input logic [15:0] port, input bit bcast, input logic [31:0] seq,
                          input logic [7:0] cmd, input int len, input bit mac_good);
    bus.to_port   = port;
    bus.broadcast = bcast;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.udp_rx_active = 1'b1;
      bus.udp_rx_data   = pkt_byte(i, seq, cmd, mac_good);
    end
    @(negedge clk);
    bus.udp_rx_active = 1'b0;
    bus.udp_rx_data   = 8'h00;
  endtask

  initial begin
    bus.udp_rx_data = 8'h00; bus.udp_rx_active = 1'b0; bus.to_port = 16'd0;
    bus.broadcast = 1'b0; bus.local_mac = MAC; bus.sending_sync = 1'b0;
    bus.discovery_ack = 1'b0; bus.erase_ack = 1'b0; bus.fifo_wrused = 10'd0;

    repeat (3) @(negedge clk);
    st = dut.state_q;
    check("rst_state", st, 3'd0);
    check("rst_disc", bus.discovery_reply, 0);
    check("rst_erase", bus.erase, 0);
    check("rst_seqerr", bus.seq_error, 0);
    check("rst_setip", bus.set_ip, 0);
    check("rst_ip", bus.assign_ip, 0);
    check("rst_nblk", bus.num_blocks, 0);
    check("rst_seqnum", bus.sequence_number, 0);
    check("rst_fifo_wr", bus.fifo_wr, 0);
    check("rst_drop", bus.pkt_drop, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Discovery with ACK after 10 high cycles while sdr_send stays busy.
    bus.sending_sync = 1'b1;
    hi_cnt = 0;
    fork
      send_pkt(16'd1024, 1'b0, 32'd1, 8'd2, 8, 1'b1);
      begin
        for (int i = 0; i < 60 && !bus.discovery_reply; i++) @(negedge clk);
        while (bus.discovery_reply && hi_cnt < 10) begin
          hi_cnt++;
          if (hi_cnt < 10) @(negedge clk);
        end
        bus.discovery_ack = 1'b1;
        @(negedge clk);
        bus.discovery_ack = 1'b0;
        check("disc_high_cycles", hi_cnt, 10);
        check("disc_after_ack", bus.discovery_reply, 0);
      end
    join
    repeat (2) @(negedge clk);
    st = dut.state_q;
    check("state_tx_while_busy", st, 3'd6);
    bus.sending_sync = 1'b0;
    repeat (2) @(negedge clk);
    st = dut.state_q;
    check("state_idle_after_sync", st, 3'd0);
    repeat (20) @(negedge clk);

    //           port    bc seq           cmd len mg wrused disc er wr   dr err seqnum       setip
    vq.push_back('{16'd1024, 0, 32'd1,        8'd2, 5,   1, 10'd0,   1, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1025, 0, 32'd99,       8'd4, 20,  1, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1025, 0, 32'd99,       8'd5, 265, 1, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 0, 32'd99,       8'd3, 15,  1, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 1, 32'd1,        8'd3, 15,  0, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 1, 32'd7,        8'd4, 5,   1, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 0, 32'd7,        8'd9, 12,  1, 10'd0,   0, 0, 0,   0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 1, 32'd2,        8'd2, 5,   1, 10'd0,   1, 0, 0,   0, 0, 32'd2,        0});
    vq.push_back('{16'd1024, 0, 32'h10,       8'd4, 5,   1, 10'd0,   0, 1, 0,   0, 0, 32'h10,       0});
    vq.push_back('{16'd1024, 0, 32'd5,        8'd5, 265, 1, 10'd0,   0, 0, 256, 0, 0, 32'd5,        0});
    vq.push_back('{16'd1024, 0, 32'd6,        8'd5, 265, 1, 10'd0,   0, 0, 256, 0, 0, 32'd6,        0});
    vq.push_back('{16'd1024, 0, 32'd8,        8'd5, 265, 1, 10'd0,   0, 0, 256, 0, 1, 32'd8,        0});
    vq.push_back('{16'd1024, 0, 32'd9,        8'd5, 300, 1, 10'd0,   0, 0, 256, 0, 1, 32'd9,        0});
    vq.push_back('{16'd1024, 0, 32'd10,       8'd5, 40,  1, 10'd0,   0, 0, 31,  0, 1, 32'd10,       0});
    vq.push_back('{16'd1024, 0, 32'h20,       8'd4, 5,   1, 10'd0,   0, 1, 0,   0, 0, 32'h20,       0});
    vq.push_back('{16'd1024, 0, 32'hFFFFFFFF, 8'd5, 265, 1, 10'd0,   0, 0, 256, 0, 0, 32'hFFFFFFFF, 0});
    vq.push_back('{16'd1024, 0, 32'd0,        8'd5, 265, 1, 10'd0,   0, 0, 256, 0, 0, 32'd0,        0});
    vq.push_back('{16'd1024, 0, 32'd1,        8'd5, 265, 1, 10'd800, 0, 0, 0,   1, 0, 32'd0,        0});
    vq.push_back('{16'd1024, 0, 32'd1,        8'd5, 265, 1, 10'd768, 0, 0, 256, 0, 0, 32'd1,        0});
    vq.push_back('{16'd1024, 1, 32'h30,       8'd3, 15,  1, 10'd0,   0, 0, 0,   0, 0, 32'h30,       1});

    foreach (vq[v]) begin
      s_wr = wr_cnt; s_drop = drop_cnt; s_disc = disc_rises; s_erase = erase_rises; s_bad = data_bad;
      bus.fifo_wrused = vq[v].wrused;
      send_pkt(vq[v].port, vq[v].bcast, vq[v].seq, vq[v].cmd, vq[v].len, vq[v].mac_good);
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_disc", v), disc_rises - s_disc, vq[v].e_disc);
      check($sformatf("v%0d_erase", v), erase_rises - s_erase, vq[v].e_erase);
      check($sformatf("v%0d_writes", v), wr_cnt - s_wr, vq[v].e_wr);
      check($sformatf("v%0d_data", v), data_bad - s_bad, 0);
      check($sformatf("v%0d_drop", v), drop_cnt - s_drop, vq[v].e_drop);
      check($sformatf("v%0d_seqerr", v), bus.seq_error, vq[v].e_err);
      check($sformatf("v%0d_seqnum", v), bus.sequence_number, vq[v].e_seqnum);
      check($sformatf("v%0d_setip", v), bus.set_ip, vq[v].e_setip);
    end
    bus.fifo_wrused = 10'd0;
    check("assign_ip", bus.assign_ip, IP);
    check("num_blocks", bus.num_blocks, NB);

    // Erase with no ACK: the request must time out after exactly 15 cycles.
    hi_cnt = 0;
    fork
      send_pkt(16'd1024, 1'b0, 32'h40, 8'd4, 5, 1'b1);
      begin
        for (int i = 0; i < 60 && !bus.erase; i++) @(negedge clk);
        while (bus.erase && hi_cnt < 100) begin
          hi_cnt++;
          @(negedge clk);
        end
      end
    join
    check("erase_timeout_cycles", hi_cnt, 15);
    repeat (5) @(negedge clk);

    // Reset in the middle of a program payload.
    bus.to_port = 16'd1024; bus.broadcast = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.udp_rx_active = 1'b1;
      bus.udp_rx_data   = pkt_byte(i, 32'h50, 8'd5, 1'b1);
    end
    @(negedge clk);
    check("pre_reset_fifo_wr", bus.fifo_wr, 1);
    rst_n = 1'b0;
    #1;
    check("reset_fifo_wr", bus.fifo_wr, 0);
    check("reset_setip", bus.set_ip, 0);
    check("reset_seqnum", bus.sequence_number, 0);
    bus.udp_rx_active = 1'b0;
    s_wr = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_writes_after_reset", wr_cnt - s_wr, 0);
    st = dut.state_q;
    check("state_after_reset", st, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
